mem_access_stage: RTL and testbench

//  MEM pipeline stage. Consumes the registered EX->MEM bundle and drives a valid/ready request and valid response port to the data cache.

---
 rtl/mem_access_stage_pkg.sv | 59 +++++
 rtl/mem_access_stage_load_align.sv | 41 ++++
 rtl/mem_access_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: memory op encoding, FSM states and
// data-cache request/response bundles.
package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NONE  = 4'd0,
        MEM_LD_B  = 4'd1,
        MEM_LD_H  = 4'd2,
        MEM_LD_W  = 4'd3,
        MEM_LD_BU = 4'd4,
        MEM_LD_HU = 4'd5,
        MEM_ST_B  = 4'd6,
        MEM_ST_H  = 4'd7,
        MEM_ST_W  = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } mem_state_t;

    // Exception vector bit raised on a misaligned access.
    localparam int unsigned EXCP_ALE_BIT = 8;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } dresp_t;

    function automatic logic op_is_load(mem_op_t op);
        return (op == MEM_LD_B) || (op == MEM_LD_H) || (op == MEM_LD_W) ||
               (op == MEM_LD_BU) || (op == MEM_LD_HU);
    endfunction

    function automatic logic op_is_store(mem_op_t op);
        return (op == MEM_ST_B) || (op == MEM_ST_H) || (op == MEM_ST_W);
    endfunction

    function automatic logic op_aligned(mem_op_t op, logic [1:0] off);
        logic ok;
        case (op)
            MEM_LD_H, MEM_LD_HU, MEM_ST_H: ok = (off[0] == 1'b0);
            MEM_LD_W, MEM_ST_W:            ok = (off == 2'b00);
            default:                       ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Extracts the addressed byte/half from a loaded word and sign- or
// zero-extends it according to the load op.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    mem_op_t     ld_op;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign ld_op = mem_op_t'(op);

    always_comb begin
        sel_b = word[7:0];
        case (offset)
            2'd0: sel_b = word[7:0];
            2'd1: sel_b = word[15:8];
            2'd2: sel_b = word[23:16];
            2'd3: sel_b = word[31:24];
            default: sel_b = word[7:0];
        endcase
        sel_h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (ld_op)
            MEM_LD_B:  data = {{24{sel_b[7]}}, sel_b};
            MEM_LD_BU: data = {24'd0, sel_b};
            MEM_LD_H:  data = {{16{sel_h[15]}}, sel_h};
            MEM_LD_HU: data = {16'd0, sel_h};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-cache requests, aligns load data, raises
// ALE on misaligned accesses and stalls the pipeline until the access completes.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned ALE_BIT = EXCP_ALE_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        excp_i,
    input  logic [9:0]  excp_num_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic        wreg_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic        dreq_valid_o,
    input  logic        dreq_ready_i,
    output logic        dreq_we_o,
    output logic [3:0]  dreq_wstrb_o,
    output logic [31:0] dreq_addr_o,
    output logic [31:0] dreq_wdata_o,
    input  logic        dresp_valid_i,
    input  logic [31:0] dresp_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        wreg_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        excp_o,
    output logic [9:0]  excp_num_o,
    output logic        stallreq_o
);

    localparam logic [9:0] ALE_MASK = 10'(1) << ALE_BIT;

    mem_op_t     op;
    mem_state_t  state;
    mem_state_t  state_nxt;
    logic        any_flush;
    logic        is_load;
    logic        is_store;
    logic        aligned;
    logic        mem_op_ok;
    logic        misaligned;
    logic        mem_go;
    logic        req_valid;
    logic        stall;
    logic        out_valid;
    logic        use_load;
    logic [3:0]  strb;
    logic [31:0] st_word;
    logic [31:0] load_data;
    dreq_t       req;
    dresp_t      resp;

    assign op         = mem_op_t'(mem_op_i);
    assign any_flush  = flush | excp_flush | ertn_flush;
    assign is_load    = op_is_load(op);
    assign is_store   = op_is_store(op);
    assign aligned    = op_aligned(op, addr_i[1:0]);
    assign mem_op_ok  = valid_i & (is_load | is_store) & ~excp_i & aligned;
    assign misaligned = valid_i & (is_load | is_store) & ~excp_i & ~aligned;
    assign mem_go     = mem_op_ok & ~any_flush & (state == S_IDLE);
    assign resp       = {dresp_valid_i, dresp_data_i};

    mem_access_stage_load_align u_load_align (
        .op     (mem_op_i),
        .offset (addr_i[1:0]),
        .word   (resp.data),
        .data   (load_data)
    );

    always_comb begin
        strb    = '0;
        st_word = st_data_i;
        case (op)
            MEM_ST_B: begin
                strb    = 4'b0001 << addr_i[1:0];
                st_word = {4{st_data_i[7:0]}};
            end
            MEM_ST_H: begin
                strb    = 4'b0011 << addr_i[1:0];
                st_word = {2{st_data_i[15:0]}};
            end
            MEM_ST_W: strb = 4'hF;
            default:  strb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Upstream holds its inputs while stalled, so the request and the load
    // offset are taken straight from the inputs in every state.
    always_comb begin
        state_nxt = state;
        req_valid = mem_go | (state == S_REQ);
        stall     = 1'b0;
        out_valid = valid_i & ~any_flush;
        use_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_go) begin
                    if (!dreq_ready_i) begin
                        state_nxt = S_REQ;
                        stall     = 1'b1;
                        out_valid = 1'b0;
                    end else if (is_load) begin
                        state_nxt = S_WAIT;
                        stall     = 1'b1;
                        out_valid = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (any_flush) begin
                    state_nxt = (dreq_ready_i && is_load) ? S_DRAIN : S_IDLE;
                end else if (!dreq_ready_i) begin
                    stall     = 1'b1;
                    out_valid = 1'b0;
                end else if (is_load) begin
                    state_nxt = S_WAIT;
                    stall     = 1'b1;
                    out_valid = 1'b0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (any_flush) begin
                    // A response coinciding with the flush is the one being dropped.
                    state_nxt = resp.valid ? S_IDLE : S_DRAIN;
                end else if (resp.valid) begin
                    state_nxt = S_IDLE;
                    use_load  = 1'b1;
                end else begin
                    stall     = 1'b1;
                    out_valid = 1'b0;
                end
            end
            S_DRAIN: begin
                if (resp.valid) begin
                    state_nxt = S_IDLE;
                end
                if (mem_op_ok && !any_flush) begin
                    stall     = 1'b1;
                    out_valid = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req = '0;
        if (req_valid) begin
            req.valid = 1'b1;
            req.we    = is_store;
            req.wstrb = strb;
            req.addr  = {addr_i[31:2], 2'b00};
            req.wdata = st_word;
        end
    end

    assign dreq_valid_o = ~rst & req.valid;
    assign dreq_we_o    = ~rst & req.we;
    assign dreq_wstrb_o = rst ? '0 : req.wstrb;
    assign dreq_addr_o  = rst ? '0 : req.addr;
    assign dreq_wdata_o = rst ? '0 : req.wdata;

    assign valid_o    = ~rst & out_valid;
    assign pc_o       = rst ? '0 : pc_i;
    assign wreg_o     = ~rst & wreg_i & ~misaligned;
    assign waddr_o    = rst ? '0 : waddr_i;
    assign wdata_o    = rst ? '0 : (use_load ? load_data : wdata_i);
    assign excp_o     = ~rst & (excp_i | misaligned);
    assign excp_num_o = rst ? '0 : (misaligned ? (excp_num_i | ALE_MASK) : excp_num_i);
    assign stallreq_o = ~rst & stall;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// transaction-level model of loads, stores, flushes and reset.
module tb_mem_access_stage;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LD_B = 4'd1, OP_LD_H = 4'd2, OP_LD_W = 4'd3,
                           OP_LD_BU = 4'd4, OP_LD_HU = 4'd5, OP_ST_B = 4'd6,
                           OP_ST_H = 4'd7, OP_ST_W = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, excp_flush = 1'b0, ertn_flush = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        excp_i = 1'b0;
    logic [9:0]  excp_num_i = '0;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] addr_i = '0, st_data_i = '0;
    logic        wreg_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        dreq_valid_o, dreq_ready_i = 1'b0, dreq_we_o;
    logic [3:0]  dreq_wstrb_o;
    logic [31:0] dreq_addr_o, dreq_wdata_o;
    logic        dresp_valid_i = 1'b0;
    logic [31:0] dresp_data_i = '0;
    logic        valid_o, wreg_o, excp_o, stallreq_o;
    logic [31:0] pc_o, wdata_o;
    logic [4:0]  waddr_o;
    logic [9:0]  excp_num_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_access_stage #(.ALE_BIT(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .valid_i(valid_i), .pc_i(pc_i), .excp_i(excp_i), .excp_num_i(excp_num_i),
        .mem_op_i(mem_op_i), .addr_i(addr_i), .st_data_i(st_data_i), .wreg_i(wreg_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .dreq_valid_o(dreq_valid_o),
        .dreq_ready_i(dreq_ready_i), .dreq_we_o(dreq_we_o), .dreq_wstrb_o(dreq_wstrb_o),
        .dreq_addr_o(dreq_addr_o), .dreq_wdata_o(dreq_wdata_o), .dresp_valid_i(dresp_valid_i),
        .dresp_data_i(dresp_data_i), .valid_o(valid_o), .pc_o(pc_o), .wreg_o(wreg_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .excp_o(excp_o), .excp_num_o(excp_num_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    // Reference: arithmetic view of load extraction and store lane placement.
    function automatic logic [31:0] ref_load(logic [3:0] op, logic [31:0] addr, logic [31:0] word);
        int unsigned off;
        logic [31:0] b, h;
        off = addr % 4;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            OP_LD_B:  return (b >= 128) ? b - 32'd256 : b;
            OP_LD_H:  return (h >= 32768) ? h - 32'd65536 : h;
            OP_LD_BU: return b;
            OP_LD_HU: return h;
            default:  return word;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(logic [3:0] op, logic [31:0] addr);
        int unsigned off;
        off = addr % 4;
        case (op)
            OP_ST_B: return 4'(1 << off);
            OP_ST_H: return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_sdata(logic [3:0] op, logic [31:0] d);
        case (op)
            OP_ST_B: return (d & 32'hFF) * 32'h0101_0101;
            OP_ST_H: return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] align_addr(logic [3:0] op, logic [31:0] a);
        if (op == OP_LD_W || op == OP_ST_W) return a & ~32'd3;
        if (op == OP_LD_H || op == OP_LD_HU || op == OP_ST_H) return a & ~32'd1;
        return a;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
        valid_i = 1'b1; mem_op_i = op; addr_i = addr; st_data_i = sdata;
        excp_i = 1'b0; excp_num_i = 10'($urandom); pc_i = $urandom;
        wreg_i = 1'b1; waddr_i = 5'($urandom); wdata_i = $urandom;
    endtask

    task automatic quiet();
        valid_i = 1'b0; mem_op_i = OP_NONE; dreq_ready_i = 1'b0; dresp_valid_i = 1'b0;
        flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] word,
                           input int unsigned rdly, input int unsigned pdly);
        logic [31:0] exp;
        logic exp_req, exp_last;
        exp = ref_load(op, addr, word);
        @(negedge clk);
        quiet();
        drive(op, addr, $urandom);
        for (int c = 0; c <= int'(rdly + pdly); c++) begin
            if (c > 0) @(negedge clk);
            exp_req  = (c <= int'(rdly));
            exp_last = (c == int'(rdly + pdly));
            dreq_ready_i  = (c == int'(rdly)) ? 1'b1 : ((c > int'(rdly)) ? 1'($urandom) : 1'b0);
            dresp_valid_i = exp_last;
            dresp_data_i  = exp_last ? word : $urandom;
            #1;
            checks++;
            if (dreq_valid_o !== exp_req) begin
                errors++; $display("FAIL load_dreq_valid op=%0d c=%0d got %b exp %b", op, c, dreq_valid_o, exp_req);
            end
            checks++;
            if (stallreq_o !== !exp_last) begin
                errors++; $display("FAIL load_stall op=%0d c=%0d got %b exp %b", op, c, stallreq_o, !exp_last);
            end
            checks++;
            if (valid_o !== exp_last) begin
                errors++; $display("FAIL load_valid op=%0d c=%0d got %b exp %b", op, c, valid_o, exp_last);
            end
            if (exp_req) begin
                checks++;
                if (dreq_addr_o !== (addr & ~32'd3) || dreq_we_o !== 1'b0) begin
                    errors++; $display("FAIL load_req c=%0d got addr %h we %b exp addr %h we 0", c, dreq_addr_o, dreq_we_o, addr & ~32'd3);
                end
            end
            if (exp_last) begin
                checks++;
                if (wdata_o !== exp || wreg_o !== 1'b1 || excp_o !== 1'b0) begin
                    errors++; $display("FAIL load_data op=%0d addr=%h word=%h got %h exp %h", op, addr, word, wdata_o, exp);
                end
            end
        end
    endtask

    task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input int unsigned rdly);
        logic last;
        @(negedge clk);
        quiet();
        drive(op, addr, sdata);
        for (int c = 0; c <= int'(rdly); c++) begin
            if (c > 0) @(negedge clk);
            last = (c == int'(rdly));
            dreq_ready_i = last;
            #1;
            checks++;
            if (dreq_valid_o !== 1'b1 || dreq_we_o !== 1'b1) begin
                errors++; $display("FAIL store_req c=%0d got valid %b we %b exp 1 1", c, dreq_valid_o, dreq_we_o);
            end
            checks++;
            if (dreq_addr_o !== (addr & ~32'd3) || dreq_wstrb_o !== ref_strb(op, addr) ||
                dreq_wdata_o !== ref_sdata(op, sdata)) begin
                errors++; $display("FAIL store_fields op=%0d c=%0d got %h/%b/%h exp %h/%b/%h", op, c,
                    dreq_addr_o, dreq_wstrb_o, dreq_wdata_o, addr & ~32'd3, ref_strb(op, addr), ref_sdata(op, sdata));
            end
            checks++;
            if (stallreq_o !== !last || valid_o !== last) begin
                errors++; $display("FAIL store_handshake c=%0d got stall %b valid %b exp %b %b", c, stallreq_o, valid_o, !last, last);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(OP_LD_W, 32'h1000, 32'h1);
        dreq_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({dreq_valid_o, dreq_we_o, dreq_wstrb_o, dreq_addr_o, dreq_wdata_o, valid_o, pc_o, wreg_o,
                 waddr_o, wdata_o, excp_o, excp_num_o, stallreq_o} !== '0) begin
                errors++; $display("FAIL reset_outputs c=%0d got nonzero exp all zero (pc_o %h valid %b)", c, pc_o, valid_o);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        quiet();
        #1;
        checks++;
        if (dreq_valid_o !== 1'b0 || stallreq_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_release got %b%b%b exp 000", dreq_valid_o, stallreq_o, valid_o);
        end
    endtask

    task automatic test_loads();
        logic [3:0] ld_ops [5];
        logic [3:0] op;
        ld_ops = '{OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU};
        do_load(OP_LD_W, 32'h1000, 32'hDEADBEEF, 0, 2);
        do_load(OP_LD_B, 32'h1003, 32'h80FF_FF00, 0, 1);
        do_load(OP_LD_BU, 32'h1003, 32'h80FF_FF00, 0, 1);
        for (int i = 0; i < 25; i++) begin
            op = ld_ops[$urandom_range(0, 4)];
            do_load(op, align_addr(op, $urandom), $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end
    endtask

    task automatic test_stores();
        logic [3:0] st_ops [3];
        logic [3:0] op;
        st_ops = '{OP_ST_B, OP_ST_H, OP_ST_W};
        do_store(OP_ST_H, 32'h2002, 32'h1234ABCD, 0);
        do_store(OP_ST_W, 32'h2000, 32'hA5A5_0F0F, 3);
        for (int i = 0; i < 20; i++) begin
            op = st_ops[$urandom_range(0, 2)];
            do_store(op, align_addr(op, $urandom), $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_store(OP_ST_B, $urandom, $urandom, 0);
            do_load(OP_LD_HU, align_addr(OP_LD_HU, $urandom), $urandom, 0, 1);
        end
    endtask

    task automatic test_misaligned();
        logic [3:0] mis_ops [6];
        logic [3:0] op;
        logic [31:0] a;
        mis_ops = '{OP_LD_H, OP_LD_HU, OP_ST_H, OP_LD_W, OP_ST_W, OP_LD_W};
        for (int i = 0; i < 12; i++) begin
            op = (i == 0) ? OP_LD_W : mis_ops[$urandom_range(0, 5)];
            a = $urandom;
            if (i == 0) a = 32'h1001;
            else if (op == OP_LD_W || op == OP_ST_W) a = (a & ~32'd3) | 32'($urandom_range(1, 3));
            else a = a | 32'd1;
            @(negedge clk);
            quiet();
            drive(op, a, $urandom);
            dreq_ready_i = 1'b1;
            #1;
            checks++;
            if (dreq_valid_o !== 1'b0 || stallreq_o !== 1'b0 || valid_o !== 1'b1) begin
                errors++; $display("FAIL misaligned_ctrl op=%0d addr=%h got dreq %b stall %b valid %b exp 0 0 1", op, a, dreq_valid_o, stallreq_o, valid_o);
            end
            checks++;
            if (excp_o !== 1'b1 || excp_num_o !== (excp_num_i | 10'h100) || wreg_o !== 1'b0) begin
                errors++; $display("FAIL misaligned_excp op=%0d got excp %b num %h wreg %b exp 1 %h 0", op, excp_o, excp_num_o, wreg_o, excp_num_i | 10'h100);
            end
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            quiet();
            drive((i % 2 == 0) ? OP_NONE : 4'($urandom_range(1, 8)), $urandom, $urandom);
            excp_i = (i % 2 == 1);
            wreg_i = 1'($urandom);
            dreq_ready_i = 1'($urandom);
            #1;
            checks++;
            if (dreq_valid_o !== 1'b0 || stallreq_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== pc_i ||
                wreg_o !== wreg_i || waddr_o !== waddr_i || wdata_o !== wdata_i ||
                excp_o !== excp_i || excp_num_o !== excp_num_i) begin
                errors++; $display("FAIL passthrough i=%0d got pc %h wd %h excp %b num %h dreq %b exp pc %h wd %h excp %b num %h dreq 0",
                    i, pc_o, wdata_o, excp_o, excp_num_o, dreq_valid_o, pc_i, wdata_i, excp_i, excp_num_i);
            end
        end
    endtask

    task automatic test_flush_wait();
        @(negedge clk); quiet();
        drive(OP_LD_W, 32'h3000, 32'h0);
        dreq_ready_i = 1'b1; #1;
        checks++;
        if (dreq_valid_o !== 1'b1 || stallreq_o !== 1'b1) begin
            errors++; $display("FAIL fw_issue got dreq %b stall %b exp 1 1", dreq_valid_o, stallreq_o);
        end
        @(negedge clk); dreq_ready_i = 1'b0; excp_flush = 1'b1; #1;
        checks++;
        if (valid_o !== 1'b0 || stallreq_o !== 1'b0 || dreq_valid_o !== 1'b0) begin
            errors++; $display("FAIL fw_flush got valid %b stall %b dreq %b exp 0 0 0", valid_o, stallreq_o, dreq_valid_o);
        end
        @(negedge clk); excp_flush = 1'b0; dresp_valid_i = 1'b1; dresp_data_i = 32'h55; dreq_ready_i = 1'b1; #1;
        checks++;
        if (valid_o !== 1'b0 || stallreq_o !== 1'b1 || dreq_valid_o !== 1'b0) begin
            errors++; $display("FAIL fw_drain got valid %b stall %b dreq %b exp 0 1 0", valid_o, stallreq_o, dreq_valid_o);
        end
        @(negedge clk); dresp_valid_i = 1'b0; dreq_ready_i = 1'b1; #1;
        checks++;
        if (dreq_valid_o !== 1'b1 || stallreq_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL fw_reissue got dreq %b stall %b valid %b exp 1 1 0", dreq_valid_o, stallreq_o, valid_o);
        end
        @(negedge clk); dreq_ready_i = 1'b0; dresp_valid_i = 1'b1; dresp_data_i = 32'hCAFE_F00D; #1;
        checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'hCAFE_F00D || stallreq_o !== 1'b0) begin
            errors++; $display("FAIL fw_complete got valid %b data %h exp 1 cafef00d", valid_o, wdata_o);
        end
    endtask

    task automatic test_flush_req();
        @(negedge clk); quiet();
        drive(OP_LD_W, 32'h4000, 32'h0); #1;
        @(negedge clk); flush = 1'b1; #1;
        checks++;
        if (dreq_valid_o !== 1'b1 || valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++; $display("FAIL fr_flush got dreq %b valid %b stall %b exp 1 0 0", dreq_valid_o, valid_o, stallreq_o);
        end
        @(negedge clk); quiet(); #1;
        checks++;
        if (dreq_valid_o !== 1'b0) begin
            errors++; $display("FAIL fr_dropped got dreq %b exp 0", dreq_valid_o);
        end
        // Flush on the accepting cycle of a load in REQ must drain the response.
        @(negedge clk); drive(OP_LD_B, 32'h4001, 32'h0); #1;
        @(negedge clk); ertn_flush = 1'b1; dreq_ready_i = 1'b1; #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL fr_acc_flush got valid %b exp 0", valid_o);
        end
        @(negedge clk); ertn_flush = 1'b0; #1;
        checks++;
        if (dreq_valid_o !== 1'b0 || stallreq_o !== 1'b1) begin
            errors++; $display("FAIL fr_drain got dreq %b stall %b exp 0 1", dreq_valid_o, stallreq_o);
        end
        @(negedge clk); dresp_valid_i = 1'b1; dresp_data_i = 32'h77; #1;
        checks++;
        if (valid_o !== 1'b0 || dreq_valid_o !== 1'b0) begin
            errors++; $display("FAIL fr_drain_resp got valid %b dreq %b exp 0 0", valid_o, dreq_valid_o);
        end
        do_load(OP_LD_B, 32'h4001, 32'h0000_8000, 0, 1);
        // Response in the same cycle as a WAIT flush returns straight to IDLE.
        do_load(OP_LD_W, 32'h5000, 32'h1, 0, 5);
        @(negedge clk); quiet(); drive(OP_LD_W, 32'h5004, 32'h0); dreq_ready_i = 1'b1; #1;
        @(negedge clk); dreq_ready_i = 1'b0; flush = 1'b1; dresp_valid_i = 1'b1; #1;
        checks++;
        if (valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++; $display("FAIL fr_wait_resp_flush got valid %b stall %b exp 0 0", valid_o, stallreq_o);
        end
        @(negedge clk); flush = 1'b0; dresp_valid_i = 1'b0; dreq_ready_i = 1'b1; #1;
        checks++;
        if (dreq_valid_o !== 1'b1) begin
            errors++; $display("FAIL fr_idle_not_drain got dreq %b exp 1", dreq_valid_o);
        end
        @(negedge clk); dreq_ready_i = 1'b0; dresp_valid_i = 1'b1; dresp_data_i = 32'h1357_9BDF; #1;
        checks++;
        if (valid_o !== 1'b1 || wdata_o !== 32'h1357_9BDF) begin
            errors++; $display("FAIL fr_after got valid %b data %h exp 1 13579bdf", valid_o, wdata_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); quiet();
        drive(OP_LD_W, 32'h6000, 32'h0); #1;
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if ({dreq_valid_o, valid_o, stallreq_o, pc_o, wdata_o, excp_o, excp_num_o} !== '0) begin
            errors++; $display("FAIL rstmid_req got dreq %b stall %b pc %h exp all zero", dreq_valid_o, stallreq_o, pc_o);
        end
        @(negedge clk); #1;
        checks++;
        if ({dreq_valid_o, dreq_addr_o, valid_o, stallreq_o, pc_o, waddr_o, wreg_o} !== '0) begin
            errors++; $display("FAIL rstmid_next got dreq %b addr %h stall %b exp all zero", dreq_valid_o, dreq_addr_o, stallreq_o);
        end
        @(negedge clk); rst = 1'b0; quiet(); dresp_valid_i = 1'b1; dresp_data_i = 32'hBAD0_BAD0; #1;
        checks++;
        if (valid_o !== 1'b0 || stallreq_o !== 1'b0 || dreq_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_stray got valid %b stall %b dreq %b exp 0 0 0", valid_o, stallreq_o, dreq_valid_o);
        end
        do_load(OP_LD_H, 32'h6002, 32'h8001_7FFF, 1, 2);
    endtask

    initial begin
        quiet();
        test_reset();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misaligned();
        test_passthrough();
        test_flush_wait();
        test_flush_req();
        test_reset_mid();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
